ex_mdu_stage: RTL and testbench
===============================

EX_MDU_STAGE -- requirements
Module: ex_mdu_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 16, 32, 64.
REQ-002 Parameter RW, default 5, register-index width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-low.
REQ-005 in_valid  in  1  upstream holds a valid instruction.
REQ-006 in_ready  out  1  stage accepts this cycle; transfer when in_valid & in_ready.
REQ-007 busA, busB  in  XLEN each  register-file operands.
REQ-008 imm  in  16  immediate; ext_op in 1: 1 = sign-extend, 0 = zero-extend to XLEN.
REQ-009 rt, rd  in  RW each; reg_dst in 1: 1 selects rt, 0 selects rd as destination.
REQ-010 alu_op  in  5  operation code from the shared package.
REQ-011 alu_src  in  1  1 = operand B is extended imm, overriding fwd_b.
REQ-012 fwd_a, fwd_b  in  2 each  forwarding selects:
  - 00 = bus.
  - 01 = wb_result.
  - 10 = mem_result.
  - 11 = bus for A, extended imm for B.
REQ-013 mem_result, wb_result  in  XLEN each  forwarded values.
REQ-014 flush  in  1  kill the in-flight and pending operation.
REQ-015 out_valid  out  1  output register holds a result.
REQ-016 out_ready  in  1  downstream accepts.
REQ-017 out_result  out  XLEN; out_zero  out  1; out_rw  out  RW; out_we  out  1 (GPR write enable).
REQ-018 busy  out  1  multiply/divide iteration in progress.

Function
REQ-019 Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA.
  - 11 MULT, 12 MULTU, 13 DIV, 14 DIVU.
  - 15 MFHI, 16 MFLO.
  - 17-31 reserved: result 0, out_we 1.
REQ-020 ADD/SUB shall wrap modulo 2^XLEN; there is no overflow trap.
REQ-021 Shifts: B shifted by A[log2(XLEN)-1:0].
REQ-022 in_ready = (state==IDLE) & (!out_valid | out_ready).
REQ-023 ALU ops and MFHI/MFLO: on accept, the output register loads on that edge; out_valid is 1 the next cycle (latency 1); out_we=1.
REQ-024 out_zero shall equal (out_result==0), registered with the result.
REQ-025 FSM states: IDLE, MUL, DIV, DONE.
  - IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU.
  - MUL/DIV->DONE after exactly XLEN iteration cycles.
  - DONE->IDLE unconditionally.
REQ-026 Operands shall be captured at accept; later changes on bus, forward or imm inputs shall not affect the operation.
REQ-027 MULT/MULTU: radix-2 shift-add; {HI,LO} = full 2*XLEN-bit product, signed for MULT.
REQ-028 DIV/DIVU: restoring divide on magnitudes; LO = quotient, HI = remainder.
  - Signed quotient sign = sign(A) xor sign(B).
  - Signed remainder sign = sign(A).
REQ-029 Divide by zero: LO = all ones, HI = dividend; the divide shall not hang.
REQ-030 Signed MIN / -1: LO = MIN, HI = 0.
REQ-031 In DONE, HI/LO update and the output register loads with out_result=0 and out_we=0, so out_valid rises XLEN+1 cycles after accept.
REQ-032 MFHI/MFLO shall always read committed HI/LO, because in_ready is low while busy.
REQ-033 out_valid & !out_ready: all out_* outputs shall hold stable.
REQ-034 In DONE with out_valid & !out_ready, the FSM shall stay in DONE until the output slot frees.
REQ-035 flush priority:
  - Any accept in the same cycle is dropped.
  - out_valid is cleared next cycle.
  - FSM returns to IDLE.
  - An aborted MULT/DIV leaves HI/LO unchanged.
REQ-036 busy = (state==MUL | state==DIV | state==DONE).

Reset
REQ-037 While rst==0 at a clock edge, the block shall take its reset state:
  - state=IDLE.
  - HI=LO=0.
  - out_valid=0, out_result=0, out_zero=1, out_rw=0, out_we=0, busy=0.
  - in_ready=0 during reset.
REQ-038 Reset mid-iteration shall abort the operation with no HI/LO update; the first accept is possible in the cycle after rst returns high.

Structure
REQ-039 A shared package ex_pkg shall hold:
  - alu_op constants and the reserved range.
  - forwarding-select constants.
  - the FSM state enum.
  - the XLEN legality check.
REQ-040 Iterative multiply/divide datapath shall be sub-module mdu_iter.
  - Inputs: start, op, operands.
  - Outputs: done, hi, lo.
  - Operand muxing, ALU, output register and FSM stay in ex_mdu_stage.

Verification
REQ-041 ADD with fwd_a=10, mem_result=5, busB=7, out_ready=1 -> next cycle out_valid=1, out_result=12, out_zero=0, out_we=1.
REQ-042 SUB with alu_src=1, ext_op=1, imm=0xFFFF, busA=0xFFFFFFFF, out_rw per reg_dst=1 -> out_result=0, out_zero=1, out_rw=rt.
REQ-043 MULT A=-3, B=7, then MFHI and MFLO:
  - in_ready is low for 33 cycles.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-044 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=9, B=0 -> LO=0xFFFFFFFF, HI=9.
REQ-045 Hold out_ready=0 across two back-to-back ADDs -> first result held stable, second accepted only after out_ready=1.
REQ-046 flush at iteration 10 of DIV, with HI/LO previously 1/2 -> MFHI=1, MFLO=2; same check with rst=0 asserted at iteration 10.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute/multiply-divide stage: op codes,
// forwarding selects, FSM states and datapath width check.
package ex_pkg;
  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_ADD    = 5'd0;
  localparam logic [OPW-1:0] OP_SUB    = 5'd1;
  localparam logic [OPW-1:0] OP_AND    = 5'd2;
  localparam logic [OPW-1:0] OP_OR     = 5'd3;
  localparam logic [OPW-1:0] OP_XOR    = 5'd4;
  localparam logic [OPW-1:0] OP_NOR    = 5'd5;
  localparam logic [OPW-1:0] OP_SLT    = 5'd6;
  localparam logic [OPW-1:0] OP_SLTU   = 5'd7;
  localparam logic [OPW-1:0] OP_SLL    = 5'd8;
  localparam logic [OPW-1:0] OP_SRL    = 5'd9;
  localparam logic [OPW-1:0] OP_SRA    = 5'd10;
  localparam logic [OPW-1:0] OP_MULT   = 5'd11;
  localparam logic [OPW-1:0] OP_MULTU  = 5'd12;
  localparam logic [OPW-1:0] OP_DIV    = 5'd13;
  localparam logic [OPW-1:0] OP_DIVU   = 5'd14;
  localparam logic [OPW-1:0] OP_MFHI   = 5'd15;
  localparam logic [OPW-1:0] OP_MFLO   = 5'd16;
  // Reserved codes produce a zero result that is still written back.
  localparam logic [OPW-1:0] OP_RSV_LO = 5'd17;
  localparam logic [OPW-1:0] OP_RSV_HI = 5'd31;

  localparam logic [1:0] FWD_BUS = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_IMM = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  function automatic bit xlen_ok(int x);
    return (x == 16) || (x == 32) || (x == 64);
  endfunction
endpackage

// File: rtl/mdu_iter.sv
// One-bit-per-cycle multiply (shift-add) and restoring divide on operand
// magnitudes, with sign fix-up applied on the registered final values.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN);

  logic            active, is_div, neg_lo, neg_hi, div0;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mc, dvd, r, q, r_nx, q_nx;
  logic [XLEN:0]   sum, shr, dif;
  logic [2*XLEN-1:0] prod, sprod;
  logic            sgn, dv;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? -x : x;
  endfunction

  assign sgn  = (op == OP_MULT) || (op == OP_DIV);
  assign dv   = (op == OP_DIV)  || (op == OP_DIVU);
  assign done = active && (cnt == CW'(XLEN-1));

  // r/q: multiply = {partial high, multiplier/low}; divide = {remainder, quotient}
  always_comb begin
    sum = {1'b0, r} + (q[0] ? {1'b0, mc} : '0);
    shr = {r, q[XLEN-1]};
    dif = shr - {1'b0, mc};
    if (is_div) begin
      if (!dif[XLEN]) begin
        r_nx = dif[XLEN-1:0];
        q_nx = {q[XLEN-2:0], 1'b1};
      end else begin
        r_nx = shr[XLEN-1:0];
        q_nx = {q[XLEN-2:0], 1'b0};
      end
    end else begin
      r_nx = sum[XLEN:1];
      q_nx = {sum[0], q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || kill) begin
      active <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      is_div <= dv;
      neg_lo <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
      neg_hi <= sgn && a[XLEN-1];
      div0   <= (b == '0);
      dvd    <= a;
      mc     <= mag(b, sgn);
      q      <= mag(a, sgn);
      r      <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      r   <= r_nx;
      q   <= q_nx;
      if (done) active <= 1'b0;
    end
  end

  always_comb begin
    prod  = {r, q};
    sprod = neg_lo ? -prod : prod;
    if (is_div) begin
      if (div0) begin
        hi = dvd;
        lo = '1;
      end else begin
        hi = neg_hi ? -r : r;
        lo = neg_lo ? -q : q;
      end
    end else begin
      hi = sprod[2*XLEN-1:XLEN];
      lo = sprod[XLEN-1:0];
    end
  end
endmodule

// File: rtl/ex_mdu_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, HI/LO with an
// iterative multiply/divide unit, and a ready/valid output register.
module ex_mdu_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] busA,
  input  logic [XLEN-1:0] busB,
  input  logic [15:0]     imm,
  input  logic            ext_op,
  input  logic [RW-1:0]   rt,
  input  logic [RW-1:0]   rd,
  input  logic            reg_dst,
  input  logic [OPW-1:0]  alu_op,
  input  logic            alu_src,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [RW-1:0]   out_rw,
  output logic            out_we,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("ex_mdu_stage: XLEN must be 16, 32 or 64");
  end

  state_t          state, state_nx;
  logic [XLEN-1:0] hi_r, lo_r, ext_imm, opa, opb, alu_res, mdu_hi, mdu_lo;
  logic [SHW-1:0]  sh;
  logic            slot_free, accept, is_mul, is_div, mdu_done, commit;

  assign ext_imm = ext_op ? XLEN'(signed'(imm)) : XLEN'(imm);

  always_comb begin
    case (fwd_a)
      FWD_WB:  opa = wb_result;
      FWD_MEM: opa = mem_result;
      default: opa = busA;
    endcase
    if (alu_src) opb = ext_imm;
    else begin
      case (fwd_b)
        FWD_WB:  opb = wb_result;
        FWD_MEM: opb = mem_result;
        FWD_IMM: opb = ext_imm;
        default: opb = busB;
      endcase
    end
  end

  assign sh = opa[SHW-1:0];

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_NOR:  alu_res = ~(opa | opb);
      OP_SLT:  alu_res = XLEN'($signed(opa) < $signed(opb));
      OP_SLTU: alu_res = XLEN'(opa < opb);
      OP_SLL:  alu_res = opb << sh;
      OP_SRL:  alu_res = opb >> sh;
      OP_SRA:  alu_res = $signed(opb) >>> sh;
      OP_MFHI: alu_res = hi_r;
      OP_MFLO: alu_res = lo_r;
      default: alu_res = '0;
    endcase
  end

  assign is_mul    = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
  assign is_div    = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = rst && (state == IDLE) && slot_free;
  assign accept    = in_valid && in_ready && !flush;
  assign commit    = (state == DONE) && slot_free && !flush;
  assign busy      = (state == MUL) || (state == DIV) || (state == DONE);

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (accept && (is_mul || is_div)),
    .kill  (flush),
    .op    (alu_op),
    .a     (opa),
    .b     (opb),
    .done  (mdu_done),
    .hi    (mdu_hi),
    .lo    (mdu_lo)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_nx = MUL;
        else if (accept && is_div) state_nx = DIV;
      end
      MUL, DIV: if (mdu_done) state_nx = DONE;
      DONE:     if (slot_free) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      hi_r       <= '0;
      lo_r       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b1;
      out_rw     <= '0;
      out_we     <= 1'b0;
    end else begin
      state <= state_nx;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (commit) begin
        // Mul/div completion occupies the slot as a non-writing token.
        hi_r       <= mdu_hi;
        lo_r       <= mdu_lo;
        out_valid  <= 1'b1;
        out_result <= '0;
        out_zero   <= 1'b1;
        out_rw     <= '0;
        out_we     <= 1'b0;
      end else if (accept && !is_mul && !is_div) begin
        out_valid  <= 1'b1;
        out_result <= alu_res;
        out_zero   <= (alu_res == '0);
        out_rw     <= reg_dst ? rt : rd;
        out_we     <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ex_mdu_stage.sv
// Directed bench for ex_mdu_stage: a reference model queues expected results
// at each accept, a per-cycle compare process checks every output transfer.
module tb_ex_mdu_stage;
  import ex_pkg::*;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid = 0, in_ready, ext_op = 0, reg_dst = 0, alu_src = 0;
  logic [XLEN-1:0] busA = 0, busB = 0, mem_result = 0, wb_result = 0;
  logic [15:0]     imm = 0;
  logic [RW-1:0]   rt = 5'd17, rd = 5'd3;
  logic [4:0]      alu_op = 0;
  logic [1:0]      fwd_a = 0, fwd_b = 0;
  logic            flush = 0, out_valid, out_ready = 1, out_zero, out_we, busy;
  logic [XLEN-1:0] out_result;
  logic [RW-1:0]   out_rw;

  ex_mdu_stage #(.XLEN(XLEN), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .busA(busA), .busB(busB), .imm(imm), .ext_op(ext_op), .rt(rt), .rd(rd),
    .reg_dst(reg_dst), .alu_op(alu_op), .alu_src(alu_src), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .mem_result(mem_result), .wb_result(wb_result),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_rw(out_rw),
    .out_we(out_we), .busy(busy)
  );

  typedef struct { logic [31:0] res; logic we; logic [4:0] rw; } exp_t;
  exp_t        q[$];
  logic [31:0] m_hi = 0, m_lo = 0;
  int          errors = 0, checks = 0;
  logic [31:0] last_res;
  logic        last_zero;
  logic [4:0]  last_rw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_m(input int op, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(a[4:0]);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a | b);
      6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7: return (a < b) ? 32'd1 : 32'd0;
      8: return b << s;
      9: return b >> s;
      10: return $signed(b) >>> s;
      15: return m_hi;
      16: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Updates the model's HI/LO for an accepted multiply or divide.
  task automatic mdu_m(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      11: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      12: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      default: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else if (op == 13) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
        else begin m_lo = a / b; m_hi = a % b; end
      end
    endcase
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] fa = 2'd0, input logic [1:0] fb = 2'd0,
                       input logic asrc = 1'b0, input logic [15:0] im = 16'h0,
                       input logic ext = 1'b0, input logic rdst = 1'b0);
    logic [31:0] ea, eb, ix;
    exp_t        e;
    int          n;
    @(posedge clk); #1;
    alu_op = op; busA = a; busB = b; fwd_a = fa; fwd_b = fb;
    alu_src = asrc; imm = im; ext_op = ext; reg_dst = rdst; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 for op %0d", op);
    end else begin
      ix = ext ? {{16{im[15]}}, im} : {16'h0, im};
      ea = (fa == 2'd1) ? wb_result : (fa == 2'd2) ? mem_result : a;
      eb = (asrc || fb == 2'd3) ? ix : (fb == 2'd1) ? wb_result : (fb == 2'd2) ? mem_result : b;
      if (op >= 11 && op <= 14) begin
        mdu_m(int'(op), ea, eb);
        e = '{res: 32'h0, we: 1'b0, rw: 5'h0};
      end else begin
        e = '{res: alu_m(int'(op), ea, eb), we: 1'b1, rw: rdst ? rt : rd};
      end
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
  endtask

  // Per-cycle compare: every transfer must match the next model entry, and a
  // stalled output must not move.
  logic        hold_prev = 0, p_zero, p_we;
  logic [31:0] p_res;
  logic [4:0]  p_rw;
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_result", out_result, p_res);
        chk("hold_zero", out_zero, p_zero);
        chk("hold_rw", out_rw, p_rw);
        chk("hold_we", out_we, p_we);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out: got out_valid=1 result %0h want no pending result", out_result);
        end else begin
          e = q.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_zero", out_zero, e.res == 32'h0);
          chk("out_we", out_we, e.we);
          if (e.we) chk("out_rw", out_rw, e.rw);
          last_res = out_result; last_zero = out_zero; last_rw = out_rw;
        end
      end
      hold_prev = out_valid && !out_ready;
      p_res = out_result; p_zero = out_zero; p_rw = out_rw; p_we = out_we;
    end
  end

  typedef struct { logic [4:0] op; logic [31:0] a, b; } vec_t;
  vec_t vt[14] = '{
    '{OP_AND,   32'hF0F0_FF00, 32'h0FF0_F0F0},
    '{OP_OR,    32'hF0F0_0000, 32'h0000_0F0F},
    '{OP_XOR,   32'hFFFF_0000, 32'h0F0F_0F0F},
    '{OP_NOR,   32'h0000_00FF, 32'hFF00_0000},
    '{OP_SLT,   32'hFFFF_FFFF, 32'h0000_0001},
    '{OP_SLTU,  32'hFFFF_FFFF, 32'h0000_0001},
    '{OP_SLL,   32'h0000_0004, 32'h0000_0001},
    '{OP_SRL,   32'h0000_0024, 32'h8000_0000},
    '{OP_SRA,   32'h0000_001F, 32'h8000_0000},
    '{OP_SUB,   32'h0000_0003, 32'h0000_0005},
    '{OP_ADD,   32'hFFFF_FFFF, 32'h0000_0001},
    '{5'd20,    32'h1234_5678, 32'h1111_1111},
    '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF}
  };

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_zero", out_zero, 1'b1);
    chk("rst_out_rw", out_rw, 5'h0);
    chk("rst_out_we", out_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b1;

    // forwarded ADD: 5 + 7
    mem_result = 32'd5;
    drive(OP_ADD, 32'd100, 32'd7, 2'd2);
    drain();
    chk("add_fwd_lit", last_res, 32'd12);
    chk("add_fwd_zero_lit", last_zero, 1'b0);

    drive(OP_SUB, 32'hFFFF_FFFF, 32'h0, 2'd0, 2'd0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    drain();
    chk("sub_imm_lit", last_res, 32'h0);
    chk("sub_imm_zero_lit", last_zero, 1'b1);
    chk("sub_imm_rw_lit", last_rw, 5'd17);

    wb_result = 32'h0000_0010;
    drive(OP_ADD, 32'h0, 32'h0, 2'd1, 2'd3, 1'b0, 16'h8000, 1'b0);
    drive(OP_OR, 32'h0, 32'h0, 2'd0, 2'd1);

    foreach (vt[i]) drive(vt[i].op, vt[i].a, vt[i].b);
    drive(OP_MFHI, 0, 0);
    drive(OP_MFLO, 0, 0);
    drain();

    // MULT -3*7; operand inputs are scrambled while the unit iterates
    drive(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    n = 0;
    busA = 32'hDEAD_BEEF; busB = 32'h1234_5678; mem_result = 32'h55; wb_result = 32'h66;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    chk("mult_stall_cycles", n, 33);
    drive(OP_MFHI, 0, 0);
    drive(OP_MFLO, 0, 0);
    drain();
    chk("mult_lo_lit", last_res, 32'hFFFF_FFEB);
    drive(OP_MFHI, 0, 0);
    drain();
    chk("mult_hi_lit", last_res, 32'hFFFF_FFFF);

    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    drive(OP_MFLO, 0, 0);
    drain();
    chk("div_lo_lit", last_res, 32'hFFFF_FFFD);
    drive(OP_MFHI, 0, 0);
    drain();
    chk("div_hi_lit", last_res, 32'hFFFF_FFFF);
    drive(OP_DIVU, 32'd9, 32'd0);
    drive(OP_MFLO, 0, 0);
    drain();
    chk("divu0_lo_lit", last_res, 32'hFFFF_FFFF);
    drive(OP_MFHI, 0, 0);
    drain();
    chk("divu0_hi_lit", last_res, 32'd9);

    // stalled output across two ADDs
    out_ready = 1'b0;
    drive(OP_ADD, 32'd1, 32'd2);
    fork
      drive(OP_ADD, 32'd3, 32'd4);
      begin
        repeat (2) @(negedge clk);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_first_res", out_result, 32'd3);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_second_lit", last_res, 32'd7);

    // flush drops a same-cycle accept
    @(posedge clk); #1;
    alu_op = OP_ADD; busA = 32'd1; busB = 32'd1; fwd_a = 0; fwd_b = 0; alu_src = 0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_drop_valid", out_valid, 1'b0);

    // HI=1, LO=2, then abort a DIV at iteration 10
    drive(OP_DIVU, 32'd7, 32'd3);
    drain();
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    void'(q.pop_back());
    m_hi = 32'd1; m_lo = 32'd2;
    @(negedge clk);
    chk("flush_busy", busy, 1'b0);
    chk("flush_out_valid", out_valid, 1'b0);
    drive(OP_MFHI, 0, 0);
    drain();
    chk("flush_hi_lit", last_res, 32'd1);
    drive(OP_MFLO, 0, 0);
    drain();
    chk("flush_lo_lit", last_res, 32'd2);

    // reset at iteration 10: divide discarded, HI/LO back to reset value
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    q.delete();
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_in_ready", in_ready, 1'b1);
    drive(OP_MFHI, 0, 0);
    drain();
    chk("rstmid_hi_lit", last_res, 32'h0);
    drive(OP_MFLO, 0, 0);
    drain();
    chk("rstmid_lo_lit", last_res, 32'h0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
